// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and helpers for the forwarding/hazard unit and its matcher.
package fwd_pkg;

   localparam int unsigned REG_W_MAX = 8;
   localparam int unsigned SEL_RF    = 0;

   // Register field is sized for the widest supported REG_W; narrower
   // addresses are zero-extended on entry and comparison.
   typedef struct packed {
      logic                 valid;
      logic [REG_W_MAX-1:0] reg_addr;
      logic                 is_load;
   } hist_entry_t;

   function automatic int unsigned min_sel_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fwd_hazard_unit_match.sv
// Priority match of one source register against the writer history.
module fwd_match
   import fwd_pkg::*;
#(
   parameter int unsigned DEPTH = 3,
   parameter int unsigned REG_W = 5,
   parameter int unsigned SEL_W = 2
) (
   input  logic [REG_W-1:0]         src,
   input  logic                     used,
   input  hist_entry_t [DEPTH-1:0]  hist,
   output logic                     hit,
   output logic [SEL_W-1:0]         k,
   output logic                     is_load
);

   logic src_live;

   assign src_live = used && (src != '0);

   // Index 0 holds the youngest writer; the first hit scanning upward wins.
   always_comb begin
      hit     = 1'b0;
      k       = SEL_W'(SEL_RF);
      is_load = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (!hit && src_live && hist[i].valid &&
             hist[i].reg_addr == REG_W_MAX'(src)) begin
            hit     = 1'b1;
            k       = SEL_W'(i + 1);
            is_load = hist[i].is_load;
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and hazard stall generation for the 5-stage pipeline.
// Optional stall statistics counters enabled by FWD_HAZARD_STATS_EN.
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int unsigned DEPTH      = 3,
   parameter int unsigned REG_W      = 5,
   parameter int unsigned SEL_W      = 2,
   parameter int unsigned LOAD_READY = 2
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_rs_used,
   input  logic             id_rt_used,
   input  logic             id_store,
   input  logic             id_branch,
   input  logic             id_load,
   input  logic             id_wr_en,
   input  logic [REG_W-1:0] id_wr_reg,
   input  logic             flush,
   output logic [SEL_W-1:0] exe_a_sel,
   output logic [SEL_W-1:0] exe_b_sel,
   output logic [SEL_W-1:0] mem_data_sel,
   output logic [SEL_W-1:0] br_a_sel,
   output logic [SEL_W-1:0] br_b_sel,
`ifdef FWD_HAZARD_STATS_EN
   output logic [31:0]      load_use_stalls,
   output logic [31:0]      branch_stalls,
`endif
   output logic             stall
);

   if (DEPTH < 2 || DEPTH > 7) begin : g_bad_depth
      $error("fwd_hazard_unit: DEPTH must be in 2..7");
   end
   if (SEL_W < min_sel_w(DEPTH)) begin : g_bad_sel_w
      $error("fwd_hazard_unit: SEL_W too narrow for DEPTH");
   end
   if (REG_W > REG_W_MAX) begin : g_bad_reg_w
      $error("fwd_hazard_unit: REG_W exceeds REG_W_MAX");
   end

   hist_entry_t [DEPTH-1:0] hist;
   hist_entry_t             new_entry;

   logic             rs_hit;
   logic [SEL_W-1:0] rs_k;
   logic             rs_load;
   logic             rt_hit;
   logic [SEL_W-1:0] rt_k;
   logic             rt_load;
   logic             rt_read;

   logic rs_early;
   logic rt_early;
   logic load_use_hit;
   logic branch_hit;
   logic advance;

   // rt is a live source both as an ALU operand and as store data.
   assign rt_read = id_rt_used || id_store;

   fwd_match #(
      .DEPTH (DEPTH),
      .REG_W (REG_W),
      .SEL_W (SEL_W)
   ) u_match_rs (
      .src     (id_rs),
      .used    (id_rs_used),
      .hist    (hist),
      .hit     (rs_hit),
      .k       (rs_k),
      .is_load (rs_load)
   );

   fwd_match #(
      .DEPTH (DEPTH),
      .REG_W (REG_W),
      .SEL_W (SEL_W)
   ) u_match_rt (
      .src     (id_rt),
      .used    (rt_read),
      .hist    (hist),
      .hit     (rt_hit),
      .k       (rt_k),
      .is_load (rt_load)
   );

   // The ID comparator cannot see the next-older result, nor a load until it is ready.
   always_comb begin
      rs_early = rs_hit && ((rs_k < SEL_W'(2)) ||
                            (rs_load && (int'(rs_k) < int'(LOAD_READY) + 1)));
      rt_early = rt_hit && ((rt_k < SEL_W'(2)) ||
                            (rt_load && (int'(rt_k) < int'(LOAD_READY) + 1)));
   end

   always_comb begin
      load_use_hit = !id_branch &&
                     ((rs_hit && rs_load && rs_k == SEL_W'(1)) ||
                      (rt_hit && rt_load && rt_k == SEL_W'(1)));
      branch_hit   = id_branch && (rs_early || rt_early);
      stall        = id_valid && !flush && (load_use_hit || branch_hit);
      advance      = id_valid && !flush && !stall;
   end

   always_comb begin
      br_a_sel = '0;
      br_b_sel = '0;
      if (id_branch && !branch_hit) begin
         br_a_sel = rs_k;
         br_b_sel = rt_k;
      end
   end

   always_comb begin
      new_entry = '0;
      if (advance && id_wr_en && id_wr_reg != '0) begin
         new_entry.valid    = 1'b1;
         new_entry.reg_addr = REG_W_MAX'(id_wr_reg);
         new_entry.is_load  = id_load;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         hist         <= '0;
         exe_a_sel    <= '0;
         exe_b_sel    <= '0;
         mem_data_sel <= '0;
      end else begin
         hist         <= {hist[DEPTH-2:0], new_entry};
         exe_a_sel    <= advance ? rs_k : '0;
         exe_b_sel    <= (advance && id_rt_used) ? rt_k : '0;
         mem_data_sel <= (advance && id_store) ? rt_k : '0;
      end
   end

`ifdef FWD_HAZARD_STATS_EN
   // Load-use attribution wins when both causes are present.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         load_use_stalls <= '0;
         branch_stalls   <= '0;
      end else if (stall) begin
         if (load_use_hit) begin
            if (load_use_stalls != '1) load_use_stalls <= load_use_stalls + 32'd1;
         end else if (branch_stalls != '1) begin
            branch_stalls <= branch_stalls + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit (DEPTH=3, LOAD_READY=2).
module tb_fwd_hazard_unit;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       id_valid, id_rs_used, id_rt_used, id_store, id_branch, id_load, id_wr_en, flush;
   logic [4:0] id_rs, id_rt, id_wr_reg;
   logic [1:0] exe_a_sel, exe_b_sel, mem_data_sel, br_a_sel, br_b_sel;
   logic       stall;
`ifdef FWD_HAZARD_STATS_EN
   logic [31:0] load_use_stalls, branch_stalls;
`endif

   int total = 0;
   int bad   = 0;

   fwd_hazard_unit #(
      .DEPTH      (3),
      .REG_W      (5),
      .SEL_W      (2),
      .LOAD_READY (2)
   ) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_rs_used   (id_rs_used),
      .id_rt_used   (id_rt_used),
      .id_store     (id_store),
      .id_branch    (id_branch),
      .id_load      (id_load),
      .id_wr_en     (id_wr_en),
      .id_wr_reg    (id_wr_reg),
      .flush        (flush),
      .exe_a_sel    (exe_a_sel),
      .exe_b_sel    (exe_b_sel),
      .mem_data_sel (mem_data_sel),
      .br_a_sel     (br_a_sel),
      .br_b_sel     (br_b_sel),
`ifdef FWD_HAZARD_STATS_EN
      .load_use_stalls (load_use_stalls),
      .branch_stalls   (branch_stalls),
`endif
      .stall        (stall)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic idle();
      id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
      id_store = 0; id_branch = 0; id_load = 0; id_wr_en = 0; id_wr_reg = 0;
      flush = 0;
   endtask

   // Places an instruction in ID and lets combinational outputs settle.
   task automatic issue(input logic [4:0] rs, input logic [4:0] rt,
                        input logic rsu, input logic rtu, input logic st,
                        input logic br, input logic ld, input logic we,
                        input logic [4:0] wr);
      id_valid = 1; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
      id_store = st; id_branch = br; id_load = ld; id_wr_en = we; id_wr_reg = wr;
      flush = 0;
      #1;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RESET = 1;
      idle();
      tick();
      RESET = 0;
   endtask

   initial begin
      idle();
      tick();
      RESET = 0;
      check("reset_exe_a", 32'(exe_a_sel), 0);
      check("reset_exe_b", 32'(exe_b_sel), 0);
      check("reset_mem",   32'(mem_data_sel), 0);
      check("reset_stall", 32'(stall), 0);
`ifdef FWD_HAZARD_STATS_EN
      check("reset_lu_cnt", load_use_stalls, 0);
      check("reset_br_cnt", branch_stalls, 0);
`endif

      // addu $3,$1,$2 ; addu $4,$3,$3
      issue(1, 2, 1, 1, 0, 0, 0, 1, 3);
      tick();
      issue(3, 3, 1, 1, 0, 0, 0, 1, 4);
      check("alu_fwd_stall", 32'(stall), 0);
      tick();
      check("alu_fwd_a", 32'(exe_a_sel), 1);
      check("alu_fwd_b", 32'(exe_b_sel), 1);

      // lw $5,0($29) ; add $6,$5,$1
      do_reset();
      issue(29, 5, 1, 0, 0, 0, 1, 1, 5);
      tick();
      issue(5, 1, 1, 1, 0, 0, 0, 1, 6);
      check("lu_stall_on", 32'(stall), 1);
      tick();
      check("lu_bubble_a", 32'(exe_a_sel), 0);
      check("lu_stall_off", 32'(stall), 0);
      tick();
      check("lu_fwd_a", 32'(exe_a_sel), 2);
      check("lu_fwd_b", 32'(exe_b_sel), 0);

      // addu $7 ; nop ; addu $7 ; addu $8,$7,$0
      do_reset();
      issue(1, 2, 1, 1, 0, 0, 0, 1, 7);
      tick();
      issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      issue(1, 2, 1, 1, 0, 0, 0, 1, 7);
      tick();
      issue(7, 0, 1, 1, 0, 0, 0, 1, 8);
      check("youngest_stall", 32'(stall), 0);
      tick();
      check("youngest_a", 32'(exe_a_sel), 1);
      check("youngest_b_r0", 32'(exe_b_sel), 0);

      // addu $9 ; beq $9,$0
      do_reset();
      issue(1, 2, 1, 1, 0, 0, 0, 1, 9);
      tick();
      issue(9, 0, 1, 1, 0, 1, 0, 0, 0);
      check("br_alu_stall", 32'(stall), 1);
      check("br_alu_sel_hold", 32'(br_a_sel), 0);
      tick();
      check("br_alu_stall_off", 32'(stall), 0);
      check("br_alu_sel", 32'(br_a_sel), 2);
      check("br_alu_sel_b", 32'(br_b_sel), 0);

      // lw $9 ; beq $9,$0 -> two stall cycles
      do_reset();
      issue(29, 9, 1, 0, 0, 0, 1, 1, 9);
      tick();
      issue(9, 0, 1, 1, 0, 1, 0, 0, 0);
      check("br_ld_stall1", 32'(stall), 1);
      tick();
      check("br_ld_stall2", 32'(stall), 1);
      check("br_ld_sel_hold", 32'(br_a_sel), 0);
      tick();
      check("br_ld_stall_off", 32'(stall), 0);
      check("br_ld_sel", 32'(br_a_sel), 3);

      // write to $0 then read $0
      do_reset();
      issue(1, 2, 1, 1, 0, 0, 0, 1, 0);
      tick();
      issue(0, 0, 1, 1, 0, 0, 0, 1, 4);
      check("r0_stall", 32'(stall), 0);
      tick();
      check("r0_a", 32'(exe_a_sel), 0);
      check("r0_b", 32'(exe_b_sel), 0);

      // addu $10 ; sw $10,0($1)
      do_reset();
      issue(1, 2, 1, 1, 0, 0, 0, 1, 10);
      tick();
      issue(1, 10, 1, 0, 1, 0, 0, 0, 0);
      check("sw_stall", 32'(stall), 0);
      tick();
      check("sw_mem", 32'(mem_data_sel), 1);
      check("sw_exe_b", 32'(exe_b_sel), 0);
      check("sw_exe_a", 32'(exe_a_sel), 0);

      // lw $10 ; sw $10 -> store-data load-use stall
      do_reset();
      issue(29, 10, 1, 0, 0, 0, 1, 1, 10);
      tick();
      issue(1, 10, 1, 0, 1, 0, 0, 0, 0);
      check("sw_lu_stall", 32'(stall), 1);
      tick();
      check("sw_lu_stall_off", 32'(stall), 0);
      tick();
      check("sw_lu_mem", 32'(mem_data_sel), 2);

      // RESET during a load-use stall
      do_reset();
      issue(29, 5, 1, 0, 0, 0, 1, 1, 5);
      tick();
      issue(5, 1, 1, 1, 0, 0, 0, 1, 6);
      check("rst_pre_stall", 32'(stall), 1);
      RESET = 1;
      tick();
      RESET = 0;
      check("rst_stall", 32'(stall), 0);
      check("rst_exe_a", 32'(exe_a_sel), 0);
      check("rst_exe_b", 32'(exe_b_sel), 0);

      // flush with a pending stall
      do_reset();
      issue(29, 5, 1, 0, 0, 0, 1, 1, 5);
      tick();
      issue(5, 1, 1, 1, 0, 0, 0, 1, 6);
      flush = 1;
      #1;
      check("flush_stall", 32'(stall), 0);
      tick();
      check("flush_exe_a", 32'(exe_a_sel), 0);
      issue(6, 5, 1, 1, 0, 0, 0, 1, 7);
      check("flush_after_stall", 32'(stall), 0);
      tick();
      check("flush_bubble_a", 32'(exe_a_sel), 0);
      check("flush_lw_b", 32'(exe_b_sel), 2);

`ifdef FWD_HAZARD_STATS_EN
      do_reset();
      for (int i = 0; i < 3; i++) begin
         issue(29, 5, 1, 0, 0, 0, 1, 1, 5);
         tick();
         issue(5, 1, 1, 1, 0, 0, 0, 1, 6);
         tick();
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         issue(1, 2, 1, 1, 0, 0, 0, 1, 9);
         tick();
         issue(9, 0, 1, 1, 0, 1, 0, 0, 0);
         tick();
         tick();
      end
      idle();
      tick();
      check("cnt_load_use", load_use_stalls, 3);
      check("cnt_branch", branch_stalls, 2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
